// File: rtl/sram_pingpong_tile_buf_if.sv
// Loader/consumer-facing bus of the ping-pong tile buffer: packed write beats in,
// per-lane narrow reads out, plus tile handshakes.
interface sram_pingpong_tile_buf_if #(
  parameter int unsigned WRWIDTH = 32,
  parameter int unsigned RDWIDTH = 4,
  parameter int unsigned ENTRYS  = 64,
  parameter int unsigned LANES   = 8
);
  localparam int unsigned AW = $clog2(ENTRYS);

  logic [AW-1:0]            max_addr;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [LANES*WRWIDTH-1:0] wr_data;
  logic                     wr_tile_done;
  logic                     rd_tile_valid;
  logic                     rd_en;
  logic [LANES*AW-1:0]      rd_addr;
  logic [LANES*RDWIDTH-1:0] rd_data;
  logic                     rd_valid;
  logic                     rd_release;
  logic [1:0]               full_cnt;

  modport master (
    output max_addr, wr_valid, wr_data, rd_en, rd_addr, rd_release,
    input  wr_ready, wr_tile_done, rd_tile_valid, rd_data, rd_valid, full_cnt
  );

  modport slave (
    input  max_addr, wr_valid, wr_data, rd_en, rd_addr, rd_release,
    output wr_ready, wr_tile_done, rd_tile_valid, rd_data, rd_valid, full_cnt
  );
endinterface

// File: rtl/sram_pingpong_tile_buf.sv
// Double-buffered per-lane scratchpad: the loader fills one bank with packed beats
// while the PE side reads narrow entries from the other.
module sram_pingpong_tile_buf #(
  parameter int unsigned WRWIDTH = 32,
  parameter int unsigned RDWIDTH = 4,
  parameter int unsigned ENTRYS  = 64,
  parameter int unsigned LANES   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sram_pingpong_tile_buf_if.slave   bus
);
  localparam int unsigned PACK  = WRWIDTH / RDWIDTH;
  localparam int unsigned AW    = $clog2(ENTRYS);
  localparam int unsigned DEPTH = 2 ** (AW + 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_state_e;

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [AW-1:0] max_q, max_d;

  logic          both_empty_c;
  logic [AW-1:0] max_eff_c;
  logic [AW:0]   wr_end_c;
  logic          wr_ready_c;
  logic          rd_tile_valid_c;
  logic          wr_accept_c;
  logic          last_beat_c;
  logic          rd_fire_c;
  logic          release_c;
  logic [1:0]    full_cnt_c;

  logic          wr_tile_done_q;
  logic          rd_valid_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wsel_q    <= 1'b0;
      rsel_q    <= 1'b0;
      wraddr_q  <= '0;
      max_q     <= AW'(ENTRYS - 1);
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      wraddr_q  <= wraddr_d;
      max_q     <= max_d;
    end
  end

  // Handshake decode; everything here depends on registers plus the request inputs only
  always_comb begin
    both_empty_c    = (bank_q[0] == EMPTY) && (bank_q[1] == EMPTY);
    max_eff_c       = both_empty_c ? bus.max_addr : max_q;
    wr_ready_c      = (bank_q[wsel_q] != FULL);
    rd_tile_valid_c = (bank_q[rsel_q] == FULL);
    wr_accept_c     = bus.wr_valid && wr_ready_c;
    wr_end_c        = {1'b0, wraddr_q} + (AW+1)'(PACK);
    last_beat_c     = wr_end_c > {1'b0, max_eff_c};
    rd_fire_c       = bus.rd_en && rd_tile_valid_c;
    release_c       = bus.rd_release && rd_tile_valid_c;
    full_cnt_c      = 2'(bank_q[0] == FULL) + 2'(bank_q[1] == FULL);
  end

  // Next-state: write-side fill/complete and read-side release act on distinct banks
  always_comb begin
    bank_d   = bank_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    wraddr_d = wraddr_q;
    max_d    = both_empty_c ? bus.max_addr : max_q;
    if (wr_accept_c) begin
      if (last_beat_c) begin
        bank_d[wsel_q] = FULL;
        wraddr_d       = '0;
        wsel_d         = ~wsel_q;
      end else begin
        if (bank_q[wsel_q] == EMPTY) bank_d[wsel_q] = FILLING;
        wraddr_d = wraddr_q + AW'(PACK);
      end
    end
    if (release_c) begin
      bank_d[rsel_q] = EMPTY;
      rsel_d         = ~rsel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_tile_done_q <= 1'b0;
      rd_valid_q     <= 1'b0;
    end else begin
      wr_tile_done_q <= wr_accept_c && last_beat_c;
      rd_valid_q     <= rd_fire_c;
    end
  end

  // Per-lane storage, indexed {bank, entry}; contents survive reset
  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [RDWIDTH-1:0] mem [DEPTH];
    logic [RDWIDTH-1:0] rd_q;
    logic [AW-1:0]      rd_addr_l;

    assign rd_addr_l = bus.rd_addr[gl*AW +: AW];

    always_ff @(posedge clk) begin
      if (wr_accept_c) begin
        for (int unsigned i = 0; i < PACK; i++) begin
          mem[{wsel_q, wraddr_q + AW'(i)}] <= bus.wr_data[gl*WRWIDTH + i*RDWIDTH +: RDWIDTH];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (rd_fire_c) begin
        rd_q <= mem[{rsel_q, rd_addr_l}];
      end
    end

    assign bus.rd_data[gl*RDWIDTH +: RDWIDTH] = rd_q;
  end

  assign bus.wr_ready      = wr_ready_c;
  assign bus.rd_tile_valid = rd_tile_valid_c;
  assign bus.full_cnt      = full_cnt_c;
  assign bus.wr_tile_done  = wr_tile_done_q;
  assign bus.rd_valid      = rd_valid_q;
endmodule

// File: tb/tb_sram_pingpong_tile_buf.sv
// Bench for the ping-pong tile buffer: tile-queue reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sram_pingpong_tile_buf;
  localparam int unsigned WRWIDTH = 32;
  localparam int unsigned RDWIDTH = 4;
  localparam int unsigned ENTRYS  = 64;
  localparam int unsigned LANES   = 8;
  localparam int unsigned PACK    = WRWIDTH / RDWIDTH;
  localparam int unsigned AW      = $clog2(ENTRYS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_pingpong_tile_buf_if #(
    .WRWIDTH(WRWIDTH), .RDWIDTH(RDWIDTH), .ENTRYS(ENTRYS), .LANES(LANES)
  ) bus ();

  sram_pingpong_tile_buf #(
    .WRWIDTH(WRWIDTH), .RDWIDTH(RDWIDTH), .ENTRYS(ENTRYS), .LANES(LANES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of completed tiles (oldest is the one being read) and a fill cursor
  logic [RDWIDTH-1:0] mmem [2][LANES][ENTRYS];
  int                 full_q [$];
  int                 fill_bank, fill_cnt, tile_len;
  logic               exp_done, exp_rvalid;
  logic [RDWIDTH-1:0] exp_rd [LANES];
  int                 m_n, m_rbank;
  bit                 m_ready, m_rtv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q.delete();
      fill_bank  = 0;
      fill_cnt   = 0;
      tile_len   = ENTRYS;
      exp_done   = 1'b0;
      exp_rvalid = 1'b0;
      for (int l = 0; l < LANES; l++) exp_rd[l] = '0;
    end else begin
      m_n     = full_q.size();
      m_ready = (m_n < 2);
      m_rtv   = (m_n > 0);
      m_rbank = m_rtv ? full_q[0] : 0;
      if (m_n == 0 && fill_cnt == 0) tile_len = int'(bus.max_addr) + 1;
      exp_rvalid = bus.rd_en && m_rtv;
      if (exp_rvalid)
        for (int l = 0; l < LANES; l++)
          exp_rd[l] = mmem[m_rbank][l][bus.rd_addr[l*AW +: AW]];
      exp_done = 1'b0;
      if (bus.wr_valid && m_ready) begin
        for (int l = 0; l < LANES; l++)
          for (int i = 0; i < PACK; i++)
            mmem[fill_bank][l][fill_cnt + i] = bus.wr_data[l*WRWIDTH + i*RDWIDTH +: RDWIDTH];
        fill_cnt += PACK;
        if (fill_cnt >= tile_len) begin
          full_q.push_back(fill_bank);
          fill_bank ^= 1;
          fill_cnt  = 0;
          exp_done  = 1'b1;
        end
      end
      if (bus.rd_release && m_rtv) void'(full_q.pop_front());
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_ready",      32'(bus.wr_ready),      32'(full_q.size() < 2));
      check("rd_tile_valid", 32'(bus.rd_tile_valid), 32'(full_q.size() > 0));
      check("full_cnt",      32'(bus.full_cnt),      32'(full_q.size()));
      check("wr_tile_done",  32'(bus.wr_tile_done),  32'(exp_done));
      check("rd_valid",      32'(bus.rd_valid),      32'(exp_rvalid));
      for (int l = 0; l < LANES; l++)
        check($sformatf("rd_data[%0d]", l), 32'(bus.rd_data[l*RDWIDTH +: RDWIDTH]), 32'(exp_rd[l]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WRWIDTH-1:0] lane_word(input logic [31:0] base, input int k, input int l);
    return (base + 32'(k)) ^ (32'(l) << 20);
  endfunction

  task automatic fill(input logic [31:0] base, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int g = 0;
      while (!bus.wr_ready && g < 50) begin
        step();
        g++;
      end
      if (g >= 50) check("wr_ready_wait", 32'(bus.wr_ready), 32'd1);
      bus.wr_valid = 1'b1;
      for (int l = 0; l < LANES; l++) bus.wr_data[l*WRWIDTH +: WRWIDTH] = lane_word(base, k, l);
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic set_rd_addr(input int a);
    for (int l = 0; l < LANES; l++) bus.rd_addr[l*AW +: AW] = AW'(a);
  endtask

  task automatic rd(input int a);
    set_rd_addr(a);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic release_bank();
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
  endtask

  function automatic logic [31:0] lane_rd(input int l);
    return 32'(bus.rd_data[l*RDWIDTH +: RDWIDTH]);
  endfunction

  initial begin
    bus.max_addr   = AW'(63);
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_release = 1'b0;
    repeat (2) step();
    check("rst_wr_ready",      32'(bus.wr_ready),      32'd1);
    check("rst_full_cnt",      32'(bus.full_cnt),      32'd0);
    check("rst_rd_tile_valid", 32'(bus.rd_tile_valid), 32'd0);
    check("rst_rd_valid",      32'(bus.rd_valid),      32'd0);
    check("rst_wr_tile_done",  32'(bus.wr_tile_done),  32'd0);
    check("rst_rd_data",       32'(bus.rd_data),       32'd0);
    rst_n = 1'b1;

    // Tile A, default 64 entries
    fill(32'h7654_3210, 8);
    check("A_tile_done",  32'(bus.wr_tile_done),  32'd1);
    check("A_tile_valid", 32'(bus.rd_tile_valid), 32'd1);
    check("A_full_cnt",   32'(bus.full_cnt),      32'd1);
    step();
    check("A_done_pulse", 32'(bus.wr_tile_done),  32'd0);
    rd(0);
    check("A_rd_valid",   32'(bus.rd_valid), 32'd1);
    check("A_addr0",      lane_rd(0),        32'h0);
    step();
    check("A_rd_valid_drop", 32'(bus.rd_valid), 32'd0);
    rd(9);
    check("A_addr9",      lane_rd(0),        32'h1);

    // Tile B fills the other bank; both banks full
    fill(32'hFEDC_BA98, 8);
    check("AB_full_cnt",  32'(bus.full_cnt), 32'd2);
    check("AB_wr_ready",  32'(bus.wr_ready), 32'd0);

    // Backpressure with both banks full
    bus.wr_valid = 1'b1;
    bus.wr_data  = {LANES{32'hDEAD_BEEF}};
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_no_done", 32'(bus.wr_tile_done), 32'd0);
    end
    bus.wr_valid = 1'b0;

    // Release A: ready only after the edge
    bus.rd_release = 1'b1;
    check("rel_ready_same_cycle", 32'(bus.wr_ready), 32'd0);
    step();
    bus.rd_release = 1'b0;
    check("rel_ready_next", 32'(bus.wr_ready), 32'd1);
    check("rel_full_cnt",   32'(bus.full_cnt), 32'd1);
    rd(0);
    check("B_addr0", lane_rd(0), 32'h8);
    release_bank();
    check("empty_full_cnt", 32'(bus.full_cnt), 32'd0);

    // Small tiles: max_addr latched at 15 while tile C is pending
    bus.max_addr = AW'(15);
    fill(32'h1111_2220, 2);
    check("C_done",     32'(bus.wr_tile_done), 32'd1);
    bus.max_addr = AW'(63);
    fill(32'hABCD_EF05, 2);
    check("D_done",     32'(bus.wr_tile_done), 32'd1);
    check("CD_full_cnt", 32'(bus.full_cnt),   32'd2);
    release_bank();
    rd(0);
    check("D_addr0",  lane_rd(0), 32'h5);
    rd(15);
    check("D_addr15", lane_rd(0), 32'hA);
    release_bank();

    // Same-cycle read and release
    fill(32'h0090_0000, 8);
    set_rd_addr(5);
    bus.rd_en      = 1'b1;
    bus.rd_release = 1'b1;
    step();
    bus.rd_en      = 1'b0;
    bus.rd_release = 1'b0;
    check("rr_rd_valid", 32'(bus.rd_valid),      32'd1);
    check("rr_lane3",    lane_rd(3),             32'hA);
    check("rr_tile_vld", 32'(bus.rd_tile_valid), 32'd0);
    check("rr_full_cnt", 32'(bus.full_cnt),      32'd0);

    // Async reset with one full tile and a partial one
    fill(32'h3333_0000, 8);
    fill(32'h5555_0000, 3);
    check("pre_rst_full_cnt", 32'(bus.full_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_full_cnt",   32'(bus.full_cnt),      32'd0);
    check("arst_wr_ready",   32'(bus.wr_ready),      32'd1);
    check("arst_tile_valid", 32'(bus.rd_tile_valid), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    fill(32'h2468_ACE0, 8);
    check("F_done",     32'(bus.wr_tile_done), 32'd1);
    check("F_full_cnt", 32'(bus.full_cnt),     32'd1);
    rd(0);
    check("F_addr0",  lane_rd(0), 32'h0);
    rd(63);
    check("F_addr63", lane_rd(0), 32'h2);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule
